axi_wr_issue: RTL

Downstream consumer of the RAW-tracking request FIFO; drains write entries from the FIFO head onto an AXI3 single-beat write channel (AW/W/B). The entry is popped only on write-response completion, so the upstream RAW check keeps covering an in-flight store until memory has accepted it. One write outstanding at a time; sticky error flag on non-OKAY response.

---
 rtl/axi_wr_issue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axi_wr_issue.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_issue
// Description : Drains write entries from the RAW-tracking FIFO head onto a
//               single-beat AXI3 write channel; pops only on B completion.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_issue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH-1:0] fifo_addr,
  input  logic [31:0]           fifo_wdata,
  input  logic [3:0]            fifo_wstrb,
  input  logic                  fifo_wr,
  output logic                  fifo_pop,
  output logic [3:0]            awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  wr_err,
  input  logic                  err_clr
);

  localparam logic [7:0] C_AWLEN   = 8'd0;
  localparam logic [2:0] C_AWSIZE  = 3'b010;
  localparam logic [1:0] C_AWBURST = 2'b01;
  localparam logic [1:0] C_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_B = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_aw_pend;
  logic                  r_w_pend;
  logic                  r_wr_err;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  logic w_aw_pend_nxt;
  logic w_w_pend_nxt;
  logic w_b_match;
  logic w_rd_discard;

  // Pending bits are only ever set while in ISSUE, so they double as the valids.
  assign w_aw_pend_nxt = r_aw_pend && !awready;
  assign w_w_pend_nxt  = r_w_pend  && !wready;
  assign w_b_match     = (r_state == S_WAIT_B) && bvalid && (bid == AXI_ID);
  assign w_rd_discard  = (r_state == S_IDLE) && !fifo_empty && !fifo_wr;

  assign fifo_pop = w_rd_discard || (w_b_match && !fifo_empty);

  assign awid    = AXI_ID;
  assign awaddr  = r_awaddr;
  assign awlen   = C_AWLEN;
  assign awsize  = C_AWSIZE;
  assign awburst = C_AWBURST;
  assign awvalid = r_aw_pend;
  assign wid     = AXI_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_w_pend;
  assign bready  = (r_state == S_WAIT_B);
  assign busy    = (r_state != S_IDLE);
  assign wr_err  = r_wr_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
      r_wr_err  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!fifo_empty && fifo_wr) begin
            r_awaddr  <= fifo_addr;
            r_wdata   <= fifo_wdata;
            r_wstrb   <= fifo_wstrb;
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_aw_pend <= w_aw_pend_nxt;
          r_w_pend  <= w_w_pend_nxt;
          if (!w_aw_pend_nxt && !w_w_pend_nxt) begin
            r_state <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          // Responses carrying a foreign ID are accepted and dropped.
          if (w_b_match) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_b_match && (bresp != C_OKAY)) begin
        r_wr_err <= 1'b1;
      end else if (err_clr) begin
        r_wr_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
